// File: rtl/mux_pipeline_sequencer.sv
// Feeds a 16-byte tile to the 4-beat, 32-bit output mux: capture, hold, step the select.
// Optional macro SEQ_SKIP_ZERO_EN skips beats whose four lane bytes are all zero.
module mux_pipeline_sequencer #(
    parameter int BYTE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*BYTE_W-1:0]  data_in,
    output logic [16*BYTE_W-1:0]  data_hold,
    output logic [1:0]            control,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  beat_last,
    output logic                  tile_done
);

    localparam int TILE_W = 16 * BYTE_W;
    localparam int BEAT_W = 4 * BYTE_W;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [1:0]          control_nxt;
    logic [TILE_W-1:0]   hold_nxt;
    logic                done_nxt;
    logic                in_fire;
    logic                beat_fire;
    logic [1:0]          last_beat;
    logic [1:0]          load_control;
    logic [1:0]          step_control;
    state_t              load_state;
    logic                load_done;

`ifdef SEQ_SKIP_ZERO_EN
    logic [3:0] mask, mask_nxt, mask_in;

    function automatic logic [3:0] beat_mask(input logic [TILE_W-1:0] d);
        logic [3:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b] = |d[b*BEAT_W +: BEAT_W];
        end
        return m;
    endfunction

    // Lowest set beat at or above start; callers guarantee one exists.
    function automatic logic [1:0] first_set_from(input logic [3:0] m, input logic [1:0] start);
        logic [1:0] r;
        r = 2'd3;
        for (int b = 3; b >= 0; b--) begin
            if (m[b] && (b >= int'(start))) begin
                r = 2'(b);
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] highest_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) begin
                r = 2'(b);
            end
        end
        return r;
    endfunction

    assign mask_in = beat_mask(data_in);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            control   <= 2'd0;
            data_hold <= '0;
            tile_done <= 1'b0;
`ifdef SEQ_SKIP_ZERO_EN
            mask      <= 4'd0;
`endif
        end else begin
            state     <= state_nxt;
            control   <= control_nxt;
            data_hold <= hold_nxt;
            tile_done <= done_nxt;
`ifdef SEQ_SKIP_ZERO_EN
            mask      <= mask_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        control_nxt = control;
        hold_nxt    = data_hold;
        done_nxt    = 1'b0;

        out_valid = (state == DRAIN);
`ifdef SEQ_SKIP_ZERO_EN
        mask_nxt     = mask;
        last_beat    = highest_set(mask);
        step_control = first_set_from(mask, control + 2'd1);
        // An all-zero tile is absorbed in IDLE and only reports completion.
        load_control = first_set_from(mask_in, 2'd0);
        load_state   = (mask_in == 4'd0) ? IDLE : DRAIN;
        load_done    = (mask_in == 4'd0);
`else
        last_beat    = 2'd3;
        step_control = control + 2'd1;
        load_control = 2'd0;
        load_state   = DRAIN;
        load_done    = 1'b0;
`endif
        beat_last = out_valid & (control == last_beat);
        // Accepting on the final accepted beat is what makes tiles back-to-back.
        in_ready  = (state == IDLE) | ((state == DRAIN) & out_ready & beat_last);
        in_fire   = in_valid & in_ready;
        beat_fire = out_valid & out_ready;

        case (state)
            IDLE: begin
                if (in_fire) begin
                    hold_nxt    = data_in;
                    control_nxt = load_control;
                    state_nxt   = load_state;
                    done_nxt    = load_done;
`ifdef SEQ_SKIP_ZERO_EN
                    mask_nxt    = mask_in;
`endif
                end
            end
            DRAIN: begin
                if (beat_fire) begin
                    if (!beat_last) begin
                        control_nxt = step_control;
                    end else begin
                        done_nxt = 1'b1;
                        if (in_fire) begin
                            hold_nxt    = data_in;
                            control_nxt = load_control;
                            state_nxt   = load_state;
`ifdef SEQ_SKIP_ZERO_EN
                            mask_nxt    = mask_in;
`endif
                        end else begin
                            control_nxt = 2'd0;
                            state_nxt   = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_pipeline_sequencer.sv
// Directed bench for mux_pipeline_sequencer; skip-zero cases are built when SEQ_SKIP_ZERO_EN is defined.
module tb_mux_pipeline_sequencer;

    localparam int BYTE_W = 8;
    localparam int TILE_W = 16 * BYTE_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [TILE_W-1:0] data_in;
    logic [TILE_W-1:0] data_hold;
    logic [1:0]        control;
    logic              out_valid;
    logic              out_ready;
    logic              beat_last;
    logic              tile_done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mux_pipeline_sequencer #(.BYTE_W(BYTE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .data_hold (data_hold),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beat_last (beat_last),
        .tile_done (tile_done)
    );

    task automatic check(input string tag, input logic [TILE_W-1:0] got, input logic [TILE_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TILE_W-1:0] mk_tile(input logic [7:0] base);
        logic [TILE_W-1:0] t;
        for (int k = 0; k < 16; k++) t[k*BYTE_W +: BYTE_W] = base + 8'(k);
        return t;
    endfunction

    logic [TILE_W-1:0] tile_one, tile_a, tile_b;
    logic [6:0]        bp_pat;
    int                exp_ctrl;

    initial begin
        tile_one = mk_tile(8'h01);
        tile_a   = mk_tile(8'h10);
        tile_b   = mk_tile(8'h20);
        bp_pat   = 7'b1011001;  // bit i = out_ready in cycle i: 1,0,0,1,1,0,1

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        tick; tick;
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_control", control, 0);
        check("rst_data_hold", data_hold, 0);
        check("rst_tile_done", tile_done, 0);
        check("rst_beat_last", beat_last, 0);

        // single tile, lanes k+1
        in_valid = 1'b1; data_in = tile_one; out_ready = 1'b1;
        #1;
        check("t1_in_ready_idle", in_ready, 1);
        tick;
        in_valid = 1'b0;
        #1;
        check("t1_hold", data_hold, tile_one);
        for (int b = 0; b < 4; b++) begin
            check("t1_out_valid", out_valid, 1);
            check("t1_control", control, b);
            check("t1_beat_last", beat_last, (b == 3));
            check("t1_tile_done", tile_done, 0);
            tick;
            #1;
        end
        check("t1_done_pulse", tile_done, 1);
        check("t1_idle_out_valid", out_valid, 0);
        check("t1_idle_in_ready", in_ready, 1);
        tick;
        check("t1_done_drop", tile_done, 0);

        // backpressure
        in_valid = 1'b1; data_in = tile_b; out_ready = 1'b0;
        tick;
        in_valid = 1'b0; data_in = '0;
        exp_ctrl = 0;
        for (int i = 0; i < 7; i++) begin
            out_ready = bp_pat[i];
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_control", control, exp_ctrl);
            check("bp_hold", data_hold, tile_b);
            check("bp_beat_last", beat_last, (exp_ctrl == 3));
            tick;
            if (bp_pat[i]) exp_ctrl++;
        end
        #1;
        check("bp_done", tile_done, 1);
        check("bp_idle", out_valid, 0);
        tick;

        // back-to-back tiles A then B
        in_valid = 1'b1; data_in = tile_a; out_ready = 1'b1;
        tick;
        data_in = tile_b;
        #1;
        for (int b = 0; b < 4; b++) begin
            check("b2b_a_valid", out_valid, 1);
            check("b2b_a_control", control, b);
            check("b2b_a_hold", data_hold, tile_a);
            check("b2b_a_in_ready", in_ready, (b == 3));
            tick;
            if (b == 3) in_valid = 1'b0;
            #1;
        end
        for (int b = 0; b < 4; b++) begin
            check("b2b_b_valid", out_valid, 1);
            check("b2b_b_control", control, b);
            check("b2b_b_hold", data_hold, tile_b);
            check("b2b_b_done", tile_done, (b == 0));
            tick;
            #1;
        end
        check("b2b_done", tile_done, 1);
        check("b2b_idle", out_valid, 0);
        tick;

        // reset mid-tile at control=2
        in_valid = 1'b1; data_in = tile_a; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick;
        check("mr_control_pre", control, 2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_control", control, 0);
        check("mr_hold", data_hold, 0);
        check("mr_tile_done", tile_done, 0);
        tick;
        check("mr_no_done", tile_done, 0);

        // in_valid during a stalled DRAIN beat
        in_valid = 1'b1; data_in = tile_a; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        out_ready = 1'b0; in_valid = 1'b1; data_in = tile_b;
        #1;
        check("st_control", control, 1);
        check("st_in_ready", in_ready, 0);
        tick;
        check("st_hold", data_hold, tile_a);
        check("st_control_hold", control, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick; tick; tick;
        check("st_done", tile_done, 1);
        tick;

`ifdef SEQ_SKIP_ZERO_EN
        // lanes 4..7 and 12..15 zero: beats 0 and 2 only
        data_in = tile_one;
        data_in[4*BYTE_W +: 4*BYTE_W]  = '0;
        data_in[12*BYTE_W +: 4*BYTE_W] = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        #1;
        check("sk_c0", control, 0);
        check("sk_bl0", beat_last, 0);
        tick;
        check("sk_c2", control, 2);
        check("sk_bl2", beat_last, 1);
        tick;
        check("sk_done", tile_done, 1);
        check("sk_idle", out_valid, 0);
        tick;

        // all-zero tile
        data_in = '0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        #1;
        check("z_out_valid", out_valid, 0);
        check("z_done", tile_done, 1);
        check("z_in_ready", in_ready, 1);
        tick;
        check("z_done_drop", tile_done, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
